// File: rtl/counter_event_logger_pkg.sv
// Shared widths and constants for the counter event logger.
// Record layout, MSB to LSB: {timestamp, rise mask, count}.
package counter_event_logger_pkg;

  localparam int LOG_EVT_W = 8;
  localparam int LOG_CNT_W = 8;
  localparam int LOG_TS_W  = 24;
  localparam int LOG_DEPTH = 16;

  localparam int REC_W   = LOG_TS_W + LOG_EVT_W + LOG_CNT_W;
  localparam int CNT_LSB = 0;
  localparam int EVT_LSB = LOG_CNT_W;
  localparam int TS_LSB  = LOG_CNT_W + LOG_EVT_W;

  localparam int DROP_W = 8;

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through FIFO holding event records.
// Pointers carry a wrap bit so full and empty are distinguishable.
module evt_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [W-1:0]             din,
  output logic                     full,
  input  logic                     rd_en,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         wr_ok, rd_ok;

  assign level = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = level[AW];
  assign dout  = mem_q[rptr_q[AW-1:0]];

  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !clr) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/counter_event_logger.sv
// Timestamps rising event flags and queues them for host readout.
// Holds edge detect, timestamp, drop accounting and the data-ready pulse.
module counter_event_logger
  import counter_event_logger_pkg::*;
#(
  parameter int EVT_W = LOG_EVT_W,
  parameter int CNT_W = LOG_CNT_W,
  parameter int TS_W  = LOG_TS_W,
  parameter int DEPTH = LOG_DEPTH
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [EVT_W-1:0]         evt_in,
  input  logic [CNT_W-1:0]         count_in,
  input  logic                     pop,
  output logic                     rd_valid,
  output logic [TS_W-1:0]          rd_ts,
  output logic [EVT_W-1:0]         rd_evt,
  output logic [CNT_W-1:0]         rd_count,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drops,
  output logic                     evt_pulse
);

  localparam int RW = TS_W + EVT_W + CNT_W;

  logic [EVT_W-1:0]  evt_q;
  logic [EVT_W-1:0]  rise;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drops_q, drops_d;
  logic              pulse_q, pulse_d;
  logic              wreq, wr_en, rd_en;
  logic              full, empty;
  logic [RW-1:0]     dout;

  assign rise  = evt_in & ~evt_q;
  assign wreq  = enable & (|rise) & ~clear;
  assign rd_en = pop & ~empty & ~clear;
  assign wr_en = wreq & (~full | rd_en);

  evt_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .clr   (clear),
    .wr_en (wr_en),
    .din   ({ts_q, rise, count_in}),
    .full  (full),
    .rd_en (rd_en),
    .dout  (dout),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    ts_d    = ts_q;
    ovf_d   = ovf_q;
    drops_d = drops_q;
    pulse_d = 1'b0;
    if (clear) begin
      ts_d    = '0;
      ovf_d   = 1'b0;
      drops_d = '0;
    end else begin
      if (enable) ts_d = ts_q + 1'b1;
      // full with no pop to make room: the record is lost
      if (wreq && full && !rd_en) begin
        ovf_d = 1'b1;
        if (drops_q != '1) drops_d = drops_q + 1'b1;
      end
      pulse_d = wr_en & empty;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      evt_q   <= '1;
      ts_q    <= '0;
      ovf_q   <= 1'b0;
      drops_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      evt_q   <= evt_in;
      ts_q    <= ts_d;
      ovf_q   <= ovf_d;
      drops_q <= drops_d;
      pulse_q <= pulse_d;
    end
  end

  assign rd_valid  = ~empty;
  assign rd_ts     = empty ? '0 : dout[RW-1 -: TS_W];
  assign rd_evt    = empty ? '0 : dout[CNT_W +: EVT_W];
  assign rd_count  = empty ? '0 : dout[CNT_W-1:0];
  assign overflow  = ovf_q;
  assign drops     = drops_q;
  assign evt_pulse = pulse_q;

endmodule

// File: tb/tb_counter_event_logger.sv
// Bench for counter_event_logger: queue-based reference model,
// per-cycle compare, directed scenarios and randomized traffic.
module tb_counter_event_logger;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] evt_in = 8'h00;
  logic [7:0] count_in = 8'h00;

  logic        rd_valid;
  logic [23:0] rd_ts;
  logic [7:0]  rd_evt;
  logic [7:0]  rd_count;
  logic [4:0]  level;
  logic        overflow;
  logic [7:0]  drops;
  logic        evt_pulse;

  always #5 clk = ~clk;

  counter_event_logger dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .enable    (enable),
    .clear     (clear),
    .evt_in    (evt_in),
    .count_in  (count_in),
    .pop       (pop),
    .rd_valid  (rd_valid),
    .rd_ts     (rd_ts),
    .rd_evt    (rd_evt),
    .rd_count  (rd_count),
    .level     (level),
    .overflow  (overflow),
    .drops     (drops),
    .evt_pulse (evt_pulse)
  );

  typedef struct packed {
    logic [23:0] ts;
    logic [7:0]  evt;
    logic [7:0]  cnt;
  } rec_t;

  int tests = 0;
  int fails = 0;

  rec_t        mq[$];
  int unsigned m_ts;
  logic [7:0]  m_prev;
  bit          m_ovf;
  int          m_drops;
  bit          m_pulse;
  bit          chk_en = 1'b0;

  task automatic m_reset();
    mq.delete();
    m_ts    = 0;
    m_prev  = 8'hFF;
    m_ovf   = 1'b0;
    m_drops = 0;
    m_pulse = 1'b0;
  endtask

  // Effect of one clock edge with the given inputs.
  task automatic model_step(input bit en, input bit cl,
                            input logic [7:0] e, input logic [7:0] c,
                            input bit p);
    logic [7:0] r;
    bit was_empty;
    bit wr;
    rec_t rec;
    r = e & ~m_prev;
    m_prev = e;
    if (cl) begin
      mq.delete();
      m_ts    = 0;
      m_ovf   = 1'b0;
      m_drops = 0;
      m_pulse = 1'b0;
    end else begin
      was_empty = (mq.size() == 0);
      wr = en && (r != 8'h00);
      if (p && !was_empty) void'(mq.pop_front());
      if (wr) begin
        if (mq.size() < D) begin
          rec.ts  = m_ts[23:0];
          rec.evt = r;
          rec.cnt = c;
          mq.push_back(rec);
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
      m_pulse = was_empty && wr;
      if (en) m_ts = (m_ts + 1) & 32'h00FF_FFFF;
    end
  endtask

  task automatic cyc(input bit en, input bit cl,
                     input logic [7:0] e, input logic [7:0] c,
                     input bit p);
    @(negedge clk);
    enable   = en;
    clear    = cl;
    evt_in   = e;
    count_in = c;
    pop      = p;
    model_step(en, cl, e, c, p);
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [23:0] ets;
    logic [7:0]  eev;
    logic [7:0]  ecn;
    logic        ev;
    logic [4:0]  elv;
    #1;
    if (rst_n && chk_en) begin
      ev  = (mq.size() != 0);
      ets = ev ? mq[0].ts  : 24'h0;
      eev = ev ? mq[0].evt : 8'h0;
      ecn = ev ? mq[0].cnt : 8'h0;
      elv = 5'(mq.size());
      tests++;
      if (rd_valid !== ev || rd_ts !== ets || rd_evt !== eev ||
          rd_count !== ecn || level !== elv || overflow !== m_ovf ||
          drops !== 8'(m_drops) || evt_pulse !== m_pulse) begin
        fails++;
        $display("FAIL cycle_cmp @%0t: got v=%b ts=%h evt=%h cnt=%h lvl=%0d ovf=%b drp=%0d pls=%b; expected v=%b ts=%h evt=%h cnt=%h lvl=%0d ovf=%b drp=%0d pls=%b",
                 $time, rd_valid, rd_ts, rd_evt, rd_count, level, overflow,
                 drops, evt_pulse, ev, ets, eev, ecn, elv, m_ovf, m_drops,
                 m_pulse);
      end
    end
  end

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_step(enable, clear, evt_in, count_in, pop);
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 8'h02, base + 8'(i), 0);
      cyc(1, 0, 8'h00, 8'h00, 0);
    end
  endtask

  initial begin
    logic [23:0] prev_ts;
    logic [7:0]  e;
    m_reset();
    repeat (3) @(posedge clk);
    release_reset();
    chk_en = 1'b1;
    chk("reset_valid", 32'(rd_valid), 0);
    chk("reset_level", 32'(level), 0);
    chk("reset_ts", 32'(rd_ts), 0);
    chk("reset_drops", 32'(drops), 0);
    chk("reset_ovf", 32'(overflow), 0);
    chk("reset_pulse", 32'(evt_pulse), 0);

    // first record at ts=5
    repeat (5) cyc(1, 0, 8'h00, 8'h00, 0);
    cyc(1, 0, 8'h01, 8'h42, 0);
    chk("t1_valid", 32'(rd_valid), 1);
    chk("t1_ts", 32'(rd_ts), 5);
    chk("t1_evt", 32'(rd_evt), 32'h01);
    chk("t1_cnt", 32'(rd_count), 32'h42);
    chk("t1_pulse", 32'(evt_pulse), 1);
    cyc(1, 0, 8'h01, 8'h42, 0);
    chk("t1_pulse_once", 32'(evt_pulse), 0);
    cyc(1, 0, 8'h01, 8'h42, 0);
    chk("t1_held_level", 32'(level), 1);

    // two lines rising together
    cyc(1, 1, 8'h00, 8'h00, 0);
    cyc(1, 0, 8'h09, 8'h11, 0);
    chk("t2_evt", 32'(rd_evt), 32'h09);
    chk("t2_level", 32'(level), 1);

    // overflow by three
    cyc(1, 1, 8'h00, 8'h00, 0);
    fill(D + 3, 8'h00);
    chk("t3_level", 32'(level), 16);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_drops", 32'(drops), 3);
    prev_ts = 24'h0;
    for (int i = 0; i < D; i++) begin
      chk("t3_order_cnt", 32'(rd_count), 32'(i));
      if (i > 0) chk("t3_ts_incr", 32'(rd_ts > prev_ts), 1);
      prev_ts = rd_ts;
      cyc(1, 0, 8'h00, 8'h00, 1);
    end
    chk("t3_drained", 32'(rd_valid), 0);

    // full, rise and pop together
    cyc(1, 1, 8'h00, 8'h00, 0);
    fill(D, 8'h00);
    cyc(1, 0, 8'h02, 8'hA5, 1);
    chk("t4_drops", 32'(drops), 0);
    chk("t4_level", 32'(level), 16);
    repeat (D - 1) cyc(1, 0, 8'h00, 8'h00, 1);
    chk("t4_tail_cnt", 32'(rd_count), 32'hA5);
    chk("t4_tail_level", 32'(level), 1);

    // enable low freezes ts and blocks logging
    cyc(0, 1, 8'h00, 8'h00, 0);
    repeat (3) cyc(1, 0, 8'h00, 8'h00, 0);
    cyc(0, 0, 8'h10, 8'h00, 0);
    chk("t5_no_rec", 32'(level), 0);
    repeat (2) cyc(0, 0, 8'h00, 8'h00, 0);
    cyc(1, 0, 8'h20, 8'h33, 0);
    chk("t5_frozen_ts", 32'(rd_ts), 3);

    // timestamp wrap
    cyc(0, 1, 8'h00, 8'h00, 0);
    @(negedge clk);
    force dut.ts_q = 24'hFFFFFF;
    enable = 1'b0;
    clear  = 1'b0;
    pop    = 1'b0;
    evt_in = 8'h00;
    model_step(0, 0, 8'h00, 8'h00, 0);
    m_ts = 32'h00FF_FFFF;
    @(posedge clk);
    #2;
    release dut.ts_q;
    cyc(1, 0, 8'h00, 8'h00, 0);
    cyc(1, 0, 8'h04, 8'h77, 0);
    chk("t5_wrap_ts", 32'(rd_ts), 0);

    // clear with rise and pop at level 5
    cyc(1, 1, 8'h00, 8'h00, 0);
    fill(D + 2, 8'h00);
    repeat (D - 5) cyc(1, 0, 8'h00, 8'h00, 1);
    chk("t6_pre_level", 32'(level), 5);
    chk("t6_pre_drops", 32'(drops), 2);
    cyc(1, 1, 8'h08, 8'h00, 1);
    chk("t6_level", 32'(level), 0);
    chk("t6_valid", 32'(rd_valid), 0);
    chk("t6_ovf", 32'(overflow), 0);
    chk("t6_drops", 32'(drops), 0);
    chk("t6_pulse", 32'(evt_pulse), 0);
    cyc(1, 0, 8'h08, 8'h00, 0);
    chk("t6_no_spurious", 32'(level), 0);
    cyc(1, 0, 8'h18, 8'h55, 0);
    chk("t6_ts_restart", 32'(rd_ts), 1);

    // random traffic
    e = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      e = e ^ 8'($urandom & $urandom & $urandom);
      cyc(($urandom % 8) != 0, ($urandom % 300) == 0, e,
          8'($urandom),
          (i < 2000) ? (($urandom % 6) == 0) : (($urandom % 2) == 0));
    end

    // async reset mid-burst
    fill(4, 8'h60);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("arst_valid", 32'(rd_valid), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_rec", 32'({rd_ts, rd_evt, rd_count}), 0);
    chk("arst_acct", 32'({overflow, drops, evt_pulse}), 0);
    repeat (2) @(posedge clk);
    release_reset();
    for (int i = 0; i < 500; i++) begin
      e = e ^ 8'($urandom & $urandom);
      cyc(1, 0, e, 8'($urandom), ($urandom % 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
